// File: rtl/qam_pkg.sv
// Shared types and constants for the 4-QAM symbol scheduler.
package qam_pkg;
  typedef enum logic [1:0] {IDLE, PREAMBLE, RUN} state_t;
  typedef logic [1:0] sym_t;
  localparam sym_t PRE_SYM_A = 2'b11;
  localparam sym_t PRE_SYM_B = 2'b00;
endpackage

// File: rtl/qam_byte_fifo.sv
// Byte FIFO, registered pointers/count; data is readable the cycle after the write.
module qam_byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_data,
  input  logic        i_rd_en,
  output logic [7:0]  o_rd_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr, w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rptr];
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/qam_symbol_scheduler.sv
// 4-QAM symbol scheduler: bytes -> MSB-first dibits, each held for SPS samples.
// Optional burst preamble enabled by defining QAM_SCHED_PREAMBLE_EN.
module qam_symbol_scheduler
  import qam_pkg::*;
#(
  parameter int SPS          = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       sample_en,
  output logic [1:0] sym_out,
  output logic       sym_start,
  output logic       tx_active
);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int SCW = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [SCW-1:0] SC_MAX = SCW'(SPS - 1);

  if (SPS < 1 || SPS > 256 || FIFO_DEPTH < 2 || PREAMBLE_LEN < 1) begin : g_bad_param
    $error("qam_symbol_scheduler: illegal parameter value");
  end

  state_t         r_state;
  logic [SCW-1:0] r_cnt;
  logic [1:0]     r_idx;
  logic [7:0]     r_shift;
  sym_t           r_sym;
  logic           r_start, r_active;

  logic [7:0]   w_rd_data;
  logic         w_full, w_empty, w_pop, w_sym_end;
  logic [FAW:0] w_count;

`ifdef QAM_SCHED_PREAMBLE_EN
  localparam int PCW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PCW-1:0] PC_MAX = PCW'(PREAMBLE_LEN - 1);
  logic [PCW-1:0] r_pre_cnt;
`endif

  qam_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst),
    .i_wr_en(byte_valid && !w_full), .i_wr_data(byte_in),
    .i_rd_en(w_pop), .o_rd_data(w_rd_data),
    .o_full(w_full), .o_empty(w_empty), .o_count(w_count)
  );

  assign byte_ready = (w_count != (FAW+1)'(FIFO_DEPTH));
  assign w_sym_end  = sample_en && (r_cnt == SC_MAX);
  assign sym_out    = r_sym;
  assign sym_start  = r_start;
  assign tx_active  = r_active;

  // Pops line up exactly with the byte loads in the FSM below.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
`ifdef QAM_SCHED_PREAMBLE_EN
      PREAMBLE: w_pop = w_sym_end && (r_pre_cnt == PC_MAX) && !w_empty;
`else
      IDLE:     w_pop = sample_en && !w_empty;
`endif
      RUN:      w_pop = w_sym_end && (r_idx == 2'd3) && !w_empty;
      default:  w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_sym    <= '0;
      r_start  <= 1'b0;
      r_active <= 1'b0;
`ifdef QAM_SCHED_PREAMBLE_EN
      r_pre_cnt <= '0;
`endif
    end else begin
      r_start <= 1'b0;
      if (sample_en) begin
        case (r_state)
          IDLE: if (!w_empty) begin
            r_start  <= 1'b1;
            r_active <= 1'b1;
            r_cnt    <= '0;
`ifdef QAM_SCHED_PREAMBLE_EN
            r_sym     <= PRE_SYM_A;
            r_pre_cnt <= '0;
            r_state   <= PREAMBLE;
`else
            r_shift <= w_rd_data;
            r_sym   <= w_rd_data[7:6];
            r_idx   <= '0;
            r_state <= RUN;
`endif
          end
`ifdef QAM_SCHED_PREAMBLE_EN
          PREAMBLE: if (w_sym_end) begin
            r_cnt <= '0;
            if (r_pre_cnt != PC_MAX) begin
              // Even-indexed preamble symbols are A, so the next one follows the current index parity.
              r_pre_cnt <= r_pre_cnt + PCW'(1);
              r_sym     <= r_pre_cnt[0] ? PRE_SYM_A : PRE_SYM_B;
              r_start   <= 1'b1;
            end else if (!w_empty) begin
              r_shift <= w_rd_data;
              r_sym   <= w_rd_data[7:6];
              r_idx   <= '0;
              r_start <= 1'b1;
              r_state <= RUN;
            end else begin
              r_active <= 1'b0;
              r_state  <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + SCW'(1);
          end
`endif
          RUN: if (w_sym_end) begin
            r_cnt <= '0;
            if (r_idx != 2'd3) begin
              r_shift <= {r_shift[5:0], 2'b00};
              r_sym   <= r_shift[5:4];
              r_idx   <= r_idx + 2'd1;
              r_start <= 1'b1;
            end else if (!w_empty) begin
              r_shift <= w_rd_data;
              r_sym   <= w_rd_data[7:6];
              r_idx   <= '0;
              r_start <= 1'b1;
            end else begin
              r_active <= 1'b0;
              r_state  <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + SCW'(1);
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Directed bench: per-cycle vector table on an SPS=4 instance, plus hand sequences on SPS=2.
module tb_qam_symbol_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a_byte = '0, b_byte = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_se = 1'b0, b_se = 1'b0;
  logic       a_ready, b_ready, a_start, b_start, a_active, b_active;
  logic [1:0] a_sym, b_sym;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qam_symbol_scheduler #(.SPS(4), .FIFO_DEPTH(4), .PREAMBLE_LEN(8)) u_dut4 (
    .clk(clk), .rst(rst), .byte_in(a_byte), .byte_valid(a_valid), .byte_ready(a_ready),
    .sample_en(a_se), .sym_out(a_sym), .sym_start(a_start), .tx_active(a_active)
  );

  qam_symbol_scheduler #(.SPS(2), .FIFO_DEPTH(4), .PREAMBLE_LEN(4)) u_dut2 (
    .clk(clk), .rst(rst), .byte_in(b_byte), .byte_valid(b_valid), .byte_ready(b_ready),
    .sample_en(b_se), .sym_out(b_sym), .sym_start(b_start), .tx_active(b_active)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       se;
    logic [1:0] sym;
    logic       start;
    logic       active;
    logic       ready;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d, input logic s,
                     input logic [1:0] sy, input logic st, input logic ac, input logic rd);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.se = s;
    x.sym = sy; x.start = st; x.active = ac; x.ready = rd;
    vq.push_back(x);
  endtask

  // n cycles of one symbol with sample_en high and no writes
  task automatic add_sym(input logic [1:0] sy, input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 8'h00, 1'b1, sy, (i == 0), 1'b1, 1'b1);
  endtask

  task automatic chk(input string name, input int idx, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: sym/start/active/ready got %b want %b", name, idx, act, exp);
    end
  endtask

  initial begin
    int mark;
    logic [1:0] syms[8];

    // reset state
    add(1, 0, 8'h00, 0, 2'b00, 0, 0, 1);
    add(1, 0, 8'h00, 0, 2'b00, 0, 0, 1);
`ifndef QAM_SCHED_PREAMBLE_EN
    // single byte 0xB4 -> 10,11,01,00
    add(0, 1, 8'hB4, 1, 2'b00, 0, 0, 1);
    add_sym(2'b10, 4); add_sym(2'b11, 4); add_sym(2'b01, 4); add_sym(2'b00, 4);
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 1);
    // 0xFF then 0x00 back-to-back; 0x00 is written while 0xFF is popped
    add(0, 1, 8'hFF, 1, 2'b00, 0, 0, 1);
    mark = vq.size();
    for (int k = 0; k < 4; k++) add_sym(2'b11, 4);
    for (int k = 0; k < 4; k++) add_sym(2'b00, 4);
    vq[mark].valid = 1'b1;
    vq[mark].data  = 8'h00;
    add(0, 0, 8'h00, 1, 2'b00, 0, 0, 1);
    // 0x4E ends on 10: sym_out must hold it once idle
    add(0, 1, 8'h4E, 1, 2'b00, 0, 0, 1);
    add_sym(2'b01, 4); add_sym(2'b00, 4); add_sym(2'b11, 4); add_sym(2'b10, 4);
    add(0, 0, 8'h00, 1, 2'b10, 0, 0, 1);
    add(0, 0, 8'h00, 1, 2'b10, 0, 0, 1);
    // fill FIFO with sample_en low; 5th byte waits for the first pop
    add(0, 1, 8'h71, 0, 2'b10, 0, 0, 1);
    add(0, 1, 8'h72, 0, 2'b10, 0, 0, 1);
    add(0, 1, 8'h73, 0, 2'b10, 0, 0, 1);
    add(0, 1, 8'h74, 0, 2'b10, 0, 0, 0);
    add(0, 1, 8'h75, 0, 2'b10, 0, 0, 0);
    add(0, 1, 8'h75, 1, 2'b01, 1, 1, 1);
    add(0, 1, 8'h75, 0, 2'b01, 0, 1, 0);
    add(1, 0, 8'h00, 0, 2'b00, 0, 0, 1);
    // three bytes, reset in the middle of byte 2's second symbol
    add(0, 1, 8'h6C, 1, 2'b00, 0, 0, 1);
    mark = vq.size();
    add_sym(2'b01, 4); add_sym(2'b10, 4); add_sym(2'b11, 4); add_sym(2'b00, 4);
    vq[mark].valid = 1'b1;   vq[mark].data = 8'h93;
    vq[mark+1].valid = 1'b1; vq[mark+1].data = 8'h5A;
    add_sym(2'b10, 4); add_sym(2'b01, 2);
    add(1, 0, 8'h00, 1, 2'b00, 0, 0, 1);
    for (int i = 0; i < 20; i++) add(0, 0, 8'h00, 1, 2'b00, 0, 0, 1);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; a_valid = vq[i].valid; a_byte = vq[i].data; a_se = vq[i].se;
      @(posedge clk); #1;
      chk("table", i, {a_sym, a_start, a_active, a_ready},
          {vq[i].sym, vq[i].start, vq[i].active, vq[i].ready});
    end
    rst = 1'b0; a_valid = 1'b0; a_se = 1'b0;

`ifndef QAM_SCHED_PREAMBLE_EN
    // SPS=2 with sample_en every third clock, byte 0x1B -> 00,01,10,11 each 6 clocks
    syms[0] = 2'b00; syms[1] = 2'b01; syms[2] = 2'b10; syms[3] = 2'b11;
    b_valid = 1'b1; b_byte = 8'h1B; b_se = 1'b0;
    @(posedge clk); #1;
    chk("slow_wr", 0, {b_sym, b_start, b_active, b_ready}, {2'b00, 1'b0, 1'b0, 1'b1});
    b_valid = 1'b0;
    for (int c = 0; c < 27; c++) begin
      b_se = (c % 3 == 0);
      @(posedge clk); #1;
      chk("slow", c, {b_sym, b_start, b_active, b_ready},
          {syms[(c < 24) ? c / 6 : 3], (c % 6 == 0) && (c < 24), (c < 24), 1'b1});
    end
`else
    // preamble 11,00,11,00 then byte 0xE4 -> 11,10,01,00
    syms[0] = 2'b11; syms[1] = 2'b00; syms[2] = 2'b11; syms[3] = 2'b00;
    syms[4] = 2'b11; syms[5] = 2'b10; syms[6] = 2'b01; syms[7] = 2'b00;
    b_valid = 1'b1; b_byte = 8'hE4; b_se = 1'b0;
    @(posedge clk); #1;
    chk("pre_wr", 0, {b_sym, b_start, b_active, b_ready}, {2'b00, 1'b0, 1'b0, 1'b1});
    b_valid = 1'b0; b_se = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      chk("pre", c, {b_sym, b_start, b_active, b_ready},
          {syms[(c < 16) ? c / 2 : 7], (c % 2 == 0) && (c < 16), (c < 16), 1'b1});
    end
`endif
    b_se = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
